// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stall/flush scheduler: state encoding and
// the per-stage control bundle.
package pipe_pkg;

  localparam logic [1:0] SCHED_RUN      = 2'd0;
  localparam logic [1:0] SCHED_MD_WAIT  = 2'd1;
  localparam logic [1:0] SCHED_MEM_WAIT = 2'd2;

  typedef enum logic [1:0] {
    StRun     = SCHED_RUN,
    StMdWait  = SCHED_MD_WAIT,
    StMemWait = SCHED_MEM_WAIT
  } sched_state_e;

  // Pipeline registers in order IF/ID, ID/EX, EX/MEM, MEM/WB.
  localparam int unsigned NumStageRegs = 4;
  localparam int unsigned IdxIfId      = 3;
  localparam int unsigned IdxIdEx      = 2;
  localparam int unsigned IdxExMem     = 1;
  localparam int unsigned IdxMemWb     = 0;

  typedef struct packed {
    logic                    pc_en;
    logic                    pc_redirect;
    logic [NumStageRegs-1:0] en;
    logic [NumStageRegs-1:0] flush;
  } stage_ctrl_t;

  function automatic stage_ctrl_t ctrl_free_run();
    stage_ctrl_t c;
    c.pc_en       = 1'b1;
    c.pc_redirect = 1'b0;
    c.en          = '1;
    c.flush       = '0;
    return c;
  endfunction

endpackage

// File: rtl/sched_md_timer.sv
// MUL/DIV wait counter for the scheduler: counts MD_WAIT cycles, raises the
// forced-release strobe and holds the sticky timeout flag until reset.
module sched_md_timer
  import pipe_pkg::*;
#(
  parameter int unsigned MD_TIMEOUT = 64,
  parameter int unsigned CNT_W      = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  sched_state_e state,
  input  logic         cnt_inc,
  input  logic         cnt_clr,
  output logic         md_timeout_fire,
  output logic         md_timeout
);

  logic [CNT_W-1:0] md_cnt_q, md_cnt_d;
  logic             md_timeout_q, md_timeout_d;

  assign md_timeout_fire = (state == StMdWait) && (md_cnt_q == CNT_W'(MD_TIMEOUT - 1));
  assign md_timeout      = md_timeout_q;

  always_comb begin
    md_cnt_d = md_cnt_q;
    if (cnt_clr) begin
      md_cnt_d = '0;
    end else if (cnt_inc && (md_cnt_q != '1)) begin
      md_cnt_d = md_cnt_q + 1'b1;
    end
  end

  assign md_timeout_d = md_timeout_q | md_timeout_fire;

  always_ff @(posedge clk) begin
    if (rst) begin
      md_cnt_q     <= '0;
      md_timeout_q <= 1'b0;
    end else begin
      md_cnt_q     <= md_cnt_d;
      md_timeout_q <= md_timeout_d;
    end
  end

endmodule

// File: rtl/pipeline_sched.sv
// Central stall/flush scheduler for the 5-stage pipeline. Define PIPE_PERF_CNT_EN
// to add the stall_cycles / flush_events performance counters.
module pipeline_sched
  import pipe_pkg::*;
#(
  parameter int unsigned MD_TIMEOUT = 64,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_hazard,
  input  logic             branch_taken,
  input  logic             md_start,
  input  logic             md_done,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             pc_redirect,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             mem_wb_flush,
  output logic             md_ack,
  output logic             md_timeout,
`ifdef PIPE_PERF_CNT_EN
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events,
`endif
  output logic [1:0]       sched_state
);

  sched_state_e state_q, state_d;
  stage_ctrl_t  ctrl;
  logic         mem_stall, md_stall, md_timeout_fire, md_active;

  sched_md_timer #(
    .MD_TIMEOUT (MD_TIMEOUT),
    .CNT_W      (CNT_W)
  ) u_md_timer (
    .clk             (clk),
    .rst             (rst),
    .state           (state_q),
    .cnt_inc         ((state_q == StMdWait) && (state_d == StMdWait)),
    .cnt_clr         (state_d == StRun),
    .md_timeout_fire (md_timeout_fire),
    .md_timeout      (md_timeout)
  );

  assign md_active = md_start | (state_q == StMdWait);
  assign mem_stall = mem_req & ~mem_ready;
  // A sticky timeout suppresses MD stalls so a hung unit cannot deadlock the pipe.
  assign md_stall  = md_active & ~md_done & ~md_timeout_fire & ~md_timeout;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun: begin
        if (mem_stall)     state_d = StMemWait;
        else if (md_stall) state_d = StMdWait;
      end
      StMdWait: begin
        if (mem_stall)     state_d = StMemWait;
        else if (!md_stall) state_d = StRun;
      end
      StMemWait: begin
        if (!mem_stall)    state_d = md_stall ? StMdWait : StRun;
      end
      default: state_d = StRun;
    endcase
  end

  always_comb begin
    ctrl = ctrl_free_run();
    if (rst) begin
      ctrl.pc_en = 1'b0;
      ctrl.en    = '0;
      ctrl.flush = '1;
    end else if (mem_stall) begin
      ctrl.pc_en            = 1'b0;
      ctrl.en[IdxIfId]      = 1'b0;
      ctrl.en[IdxIdEx]      = 1'b0;
      ctrl.en[IdxExMem]     = 1'b0;
      ctrl.flush[IdxMemWb]  = 1'b1;
    end else if (md_stall) begin
      ctrl.pc_en            = 1'b0;
      ctrl.en[IdxIfId]      = 1'b0;
      ctrl.en[IdxIdEx]      = 1'b0;
      ctrl.flush[IdxExMem]  = 1'b1;
    end else if (load_hazard) begin
      ctrl.pc_en            = 1'b0;
      ctrl.en[IdxIfId]      = 1'b0;
      ctrl.flush[IdxIdEx]   = 1'b1;
    end else if (branch_taken) begin
      ctrl.pc_redirect      = 1'b1;
      ctrl.flush[IdxIfId]   = 1'b1;
      ctrl.flush[IdxIdEx]   = 1'b1;
    end
  end

  assign pc_en        = ctrl.pc_en;
  assign pc_redirect  = ctrl.pc_redirect;
  assign if_id_en     = ctrl.en[IdxIfId];
  assign id_ex_en     = ctrl.en[IdxIdEx];
  assign ex_mem_en    = ctrl.en[IdxExMem];
  assign mem_wb_en    = ctrl.en[IdxMemWb];
  assign if_id_flush  = ctrl.flush[IdxIfId];
  assign id_ex_flush  = ctrl.flush[IdxIdEx];
  assign ex_mem_flush = ctrl.flush[IdxExMem];
  assign mem_wb_flush = ctrl.flush[IdxMemWb];
  // A result held during a MEM stall is acknowledged only once EX/MEM advances.
  assign md_ack       = ex_mem_en & md_done & md_active;
  assign sched_state  = state_q;

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cycles_q, flush_events_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q <= '0;
      flush_events_q <= '0;
    end else begin
      if (!pc_en)      stall_cycles_q <= stall_cycles_q + 1'b1;
      if (pc_redirect) flush_events_q <= flush_events_q + 1'b1;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_events = flush_events_q;
`endif

endmodule
